// File: rtl/pipelined_prefix_adder_pkg.sv
// Shared definitions for the pipelined prefix adder: op codes, default sizes
// and the bit order of the registered flag vector.
package pipelined_prefix_adder_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_GROUP = 4;
  localparam int DEF_TAGW  = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SBB = 2'b10,
    OP_ADC = 2'b11
  } op_e;

  localparam int FLG_COUT = 0;
  localparam int FLG_OVF  = 1;
  localparam int FLG_ZERO = 2;
  localparam int FLG_LT_S = 3;
  localparam int FLG_LT_U = 4;
  localparam int NFLG     = 5;

  typedef logic [NFLG-1:0] flags_t;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction
endpackage

// File: rtl/pipelined_prefix_adder_tree.sv
// Combinational Sklansky tree over N group (G,P) pairs with a carry-in;
// c[k] is the carry into group k. o_logic is the single prefix node cell.
module o_logic (
  input  logic gi,
  input  logic pi,
  input  logic gj,
  input  logic pj,
  output logic go,
  output logic po
);
  assign go = gi | (pi & gj);
  assign po = pi & pj;
endmodule

module prefix_gp_tree #(
  parameter int N = 8
) (
  input  logic [N-1:0] g,
  input  logic [N-1:0] p,
  input  logic         cin,
  output logic [N-1:0] c
);
  localparam int LVL = $clog2(N);

  logic [LVL:0][N-1:0] gl;
  logic [LVL:0][N-1:0] pl;

  // folding cin into group 0 turns every prefix G directly into a carry
  assign gl[0] = {g[N-1:1], g[0] | (p[0] & cin)};
  assign pl[0] = p;

  for (genvar l = 0; l < LVL; l++) begin : g_lvl
    for (genvar i = 0; i < N; i++) begin : g_col
      if (((i >> l) & 1) == 1) begin : g_node
        localparam int J = ((i >> l) << l) - 1;
        o_logic u_o (
          .gi(gl[l][i]), .pi(pl[l][i]),
          .gj(gl[l][J]), .pj(pl[l][J]),
          .go(gl[l+1][i]), .po(pl[l+1][i])
        );
      end else begin : g_pass
        assign gl[l+1][i] = gl[l][i];
        assign pl[l+1][i] = pl[l][i];
      end
    end
  end

  assign c = {gl[LVL][N-2:0], cin};

  logic unused_tail;
  assign unused_tail = gl[LVL][N-1] ^ (^pl[LVL]);
endmodule

// File: rtl/pipelined_prefix_adder.sv
// 3-stage add/sub/compare unit: S1 group G/P, S2 Sklansky group carries,
// S3 in-group ripple, sum and flags into the output registers.
import pipelined_prefix_adder_pkg::*;

module pipelined_prefix_adder #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP,
  parameter int TAGW  = DEF_TAGW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [1:0]       in_op,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_lt_s,
  output logic             out_lt_u,
  output logic [TAGW-1:0]  out_tag
);
  localparam int NGRP = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0 || NGRP < 2 || !is_pow2(NGRP)) begin : g_bad_param
    $error("pipelined_prefix_adder: WIDTH/GROUP must give a power-of-2 group count >= 2");
  end

  logic [3:1] vld_pipe;
  logic       rst_q;
  logic       adv1, adv2, adv3, accept;

  assign adv3     = ~vld_pipe[3] | out_ready;
  assign adv2     = ~vld_pipe[2] | adv3;
  assign adv1     = ~vld_pipe[1] | adv2;
  // rst_q keeps in_ready low for the cycle right after a reset
  assign in_ready = ~rst_q & adv1;
  assign accept   = in_valid & in_ready;
  assign out_valid = vld_pipe[3];

  // ---- S1: operand prep and per-group (G,P)
  op_e              op_in;
  logic             sub_in, c0_in;
  logic [WIDTH-1:0] bp, g_in, p_in;
  logic [NGRP-1:0]  gg_in, gp_in;

  assign op_in  = op_e'(in_op);
  assign sub_in = (op_in == OP_SUB) || (op_in == OP_SBB);
  assign c0_in  = (op_in == OP_SUB) ? 1'b1 : in_cin;
  assign bp     = sub_in ? ~in_b : in_b;
  assign g_in   = in_a & bp;
  assign p_in   = in_a ^ bp;

  always_comb begin
    gg_in = '0;
    gp_in = '1;
    for (int k = 0; k < NGRP; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        gg_in[k] = g_in[k*GROUP+j] | (p_in[k*GROUP+j] & gg_in[k]);
        gp_in[k] = gp_in[k] & p_in[k*GROUP+j];
      end
    end
  end

  logic [WIDTH-1:0] s1_g, s1_p;
  logic [NGRP-1:0]  s1_gg, s1_gp;
  logic             s1_c0;
  op_e              s1_op;
  logic [TAGW-1:0]  s1_tag;

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_g   <= g_in;
      s1_p   <= p_in;
      s1_gg  <= gg_in;
      s1_gp  <= gp_in;
      s1_c0  <= c0_in;
      s1_op  <= op_in;
      s1_tag <= in_tag;
    end
  end

  // ---- S2: group carry-ins from the prefix tree
  logic [NGRP-1:0]  grp_c, s2_c;
  logic [WIDTH-1:0] s2_g, s2_p;
  op_e              s2_op;
  logic [TAGW-1:0]  s2_tag;

  prefix_gp_tree #(.N(NGRP)) u_tree (
    .g(s1_gg), .p(s1_gp), .cin(s1_c0), .c(grp_c)
  );

  always_ff @(posedge clk) begin
    if (adv2 && vld_pipe[1]) begin
      s2_c   <= grp_c;
      s2_g   <= s1_g;
      s2_p   <= s1_p;
      s2_op  <= s1_op;
      s2_tag <= s1_tag;
    end
  end

  // ---- S3: in-group ripple, sum and flags
  logic [WIDTH-1:0] s3_sum;
  logic             rc, c_msb, s3_sub, s3_ovf;
  flags_t           s3_flags, out_flags;

  always_comb begin
    s3_sum = '0;
    rc     = 1'b0;
    c_msb  = 1'b0;
    for (int k = 0; k < NGRP; k++) begin
      rc = s2_c[k];
      for (int j = 0; j < GROUP; j++) begin
        s3_sum[k*GROUP+j] = s2_p[k*GROUP+j] ^ rc;
        c_msb = rc;
        rc = s2_g[k*GROUP+j] | (s2_p[k*GROUP+j] & rc);
      end
    end
  end

  assign s3_sub = (s2_op == OP_SUB) || (s2_op == OP_SBB);
  assign s3_ovf = c_msb ^ rc;

  always_comb begin
    s3_flags           = '0;
    s3_flags[FLG_COUT] = rc;
    s3_flags[FLG_OVF]  = s3_ovf;
    s3_flags[FLG_ZERO] = ~|s3_sum;
    s3_flags[FLG_LT_S] = s3_sub & (s3_sum[WIDTH-1] ^ s3_ovf);
    s3_flags[FLG_LT_U] = s3_sub & ~rc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      rst_q     <= 1'b1;
      out_sum   <= '0;
      out_flags <= '0;
      out_tag   <= '0;
    end else begin
      rst_q <= 1'b0;
      if (adv1) vld_pipe[1] <= accept;
      if (adv2) vld_pipe[2] <= vld_pipe[1];
      if (adv3) begin
        vld_pipe[3] <= vld_pipe[2];
        if (vld_pipe[2]) begin
          out_sum   <= s3_sum;
          out_flags <= s3_flags;
          out_tag   <= s2_tag;
        end
      end
    end
  end

  assign out_cout = out_flags[FLG_COUT];
  assign out_ovf  = out_flags[FLG_OVF];
  assign out_zero = out_flags[FLG_ZERO];
  assign out_lt_s = out_flags[FLG_LT_S];
  assign out_lt_u = out_flags[FLG_LT_U];
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: a 32/4 instance and an 8/4 (one-level tree)
// instance share stimulus and are scored against an arithmetic reference model.
module tb_pipelined_prefix_adder;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_cin, out_ready;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_op;
  logic [3:0]  in_tag;

  logic        in_ready, out_valid, out_cout, out_ovf, out_zero, out_lt_s, out_lt_u;
  logic [31:0] out_sum;
  logic [3:0]  out_tag;
  logic        in_ready8, out_valid8, out_cout8, out_ovf8, out_zero8, out_lt_s8, out_lt_u8;
  logic [7:0]  out_sum8;
  logic [3:0]  out_tag8;

  always #5 clk = ~clk;

  pipelined_prefix_adder #(.WIDTH(32), .GROUP(4), .TAGW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero),
    .out_lt_s(out_lt_s), .out_lt_u(out_lt_u), .out_tag(out_tag)
  );

  pipelined_prefix_adder #(.WIDTH(8), .GROUP(4), .TAGW(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_cin(in_cin), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid8), .out_ready(out_ready), .out_sum(out_sum8),
    .out_cout(out_cout8), .out_ovf(out_ovf8), .out_zero(out_zero8),
    .out_lt_s(out_lt_s8), .out_lt_u(out_lt_u8), .out_tag(out_tag8)
  );

  typedef struct packed {
    logic [3:0]  tag;
    logic        lt_u, lt_s, zero, ovf, cout;
    logic [63:0] sum;
  } res_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  bit   lat_chk = 1'b0;
  res_t q32[$];
  res_t q8[$];
  int   qa[$];

  // Reference: A + B' + c0 in wide arithmetic; flags from true signed/unsigned values.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic cin,
                                 input logic [1:0] op, input logic [3:0] tag, input int w);
    res_t r;
    logic [64:0] mask, am, bm, bp, full;
    logic sub, c0, brw;
    logic signed [67:0] sa, sb, tr, lim;
    mask = (65'd1 << w) - 65'd1;
    am   = {1'b0, a} & mask;
    bm   = {1'b0, b} & mask;
    sub  = (op == 2'd1) || (op == 2'd2);
    c0   = (op == 2'd1) ? 1'b1 : cin;
    brw  = sub & ~c0;
    bp   = sub ? (~bm & mask) : bm;
    full = am + bp + {64'b0, c0};
    sa = $signed({3'b0, am});
    if (am[w-1]) sa = sa - (68'sd1 <<< w);
    sb = $signed({3'b0, bm});
    if (bm[w-1]) sb = sb - (68'sd1 <<< w);
    tr  = sub ? (sa - sb - (brw ? 68'sd1 : 68'sd0)) : (sa + sb + (c0 ? 68'sd1 : 68'sd0));
    lim = 68'sd1 <<< (w - 1);
    r.sum  = full[63:0] & mask[63:0];
    r.cout = full[w];
    r.ovf  = (tr >= lim) || (tr < -lim);
    r.zero = (r.sum == 64'd0);
    r.lt_s = sub && (tr < 0);
    r.lt_u = sub && (am < bm + {64'b0, brw});
    r.tag  = tag;
    return r;
  endfunction

  function automatic res_t got32();
    return {out_tag, out_lt_u, out_lt_s, out_zero, out_ovf, out_cout, 32'b0, out_sum};
  endfunction

  function automatic res_t got8();
    return {out_tag8, out_lt_u8, out_lt_s8, out_zero8, out_ovf8, out_cout8, 56'b0, out_sum8};
  endfunction

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One cycle: drive at negedge, score handshakes, then advance to next negedge.
  task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic [1:0] op, input logic [3:0] tag, input logic ordy);
    res_t e;
    int   acc;
    in_valid = iv; in_a = a; in_b = b; in_cin = cin; in_op = op; in_tag = tag; out_ready = ordy;
    #1;
    if (!rst) begin
      if (out_valid && out_ready) begin
        chk("emit32_expected", 128'(q32.size() != 0), 128'd1);
        if (q32.size() != 0) begin
          e = q32.pop_front();
          acc = qa.pop_front();
          chk("res32", 128'(got32()), 128'(e));
          if (lat_chk) chk("latency", 128'(cyc - acc), 128'd3);
        end
      end
      if (out_valid8 && out_ready) begin
        chk("emit8_expected", 128'(q8.size() != 0), 128'd1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          chk("res8", 128'(got8()), 128'(e));
        end
      end
      if (in_valid && in_ready) begin
        q32.push_back(model({32'b0, a}, {32'b0, b}, cin, op, tag, 32));
        qa.push_back(cyc);
        acc_cnt++;
      end
      if (in_valid && in_ready8)
        q8.push_back(model({56'b0, a[7:0]}, {56'b0, b[7:0]}, cin, op, tag, 8));
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 4'd0, ordy);
  endtask

  initial begin
    res_t snap;
    int   base;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    in_op = 2'd0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_outs32", 128'({in_ready, got32(), out_valid}), 128'd0);
    chk("reset_outs8", 128'({in_ready8, got8(), out_valid8}), 128'd0);
    idle(1'b1);
    chk("ready_after_reset", 128'({in_ready, in_ready8}), 128'b11);

    // ADD wrap, with explicit latency observation
    lat_chk = 1'b1;
    step(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 2'd0, 4'd1, 1'b1);
    chk("lat_c1", 128'(out_valid), 128'd0);
    idle(1'b1);
    chk("lat_c2", 128'(out_valid), 128'd0);
    idle(1'b1);
    chk("add_wrap", 128'({out_valid, out_sum, out_cout, out_zero, out_ovf, out_lt_s, out_lt_u}),
        128'({1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));

    step(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'd1, 4'd2, 1'b1);
    step(1'b1, 32'h5, 32'h3, 1'b0, 2'd2, 4'd3, 1'b1);
    idle(1'b1);
    chk("sub_ovf", 128'({out_sum, out_cout, out_ovf, out_lt_s, out_lt_u}),
        128'({32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1}));
    idle(1'b1);
    chk("sbb_5_3", 128'({out_sum, out_cout}), 128'({32'h1, 1'b1}));
    repeat (3) idle(1'b1);

    // back-to-back stream of tags 0..7
    for (int t = 0; t < 8; t++) begin
      chk("stream_ready", 128'(in_ready), 128'd1);
      step(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'(t), 1'b1);
    end
    repeat (4) idle(1'b1);
    chk("stream_drained", 128'(q32.size() + q8.size()), 128'd0);
    lat_chk = 1'b0;

    // full stall: exactly 3 accepted, outputs held
    base = acc_cnt;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) snap = got32();
      if (i > 3) chk("stall_hold", 128'(got32()), 128'(snap));
      step(1'b1, pick(), pick(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'(8 + i), 1'b0);
    end
    chk("stall_accepts", 128'(acc_cnt - base), 128'd3);
    chk("stall_not_ready", 128'({in_ready, out_valid}), 128'b01);
    repeat (6) idle(1'b1);
    chk("stall_drained", 128'(q32.size() + q8.size()), 128'd0);

    // reset with ops in flight
    repeat (3) step(1'b1, pick(), pick(), 1'b1, 2'd0, 4'hA, 1'b0);
    rst = 1'b1;
    idle(1'b1);
    rst = 1'b0;
    q32.delete(); q8.delete(); qa.delete();
    chk("rst_flight32", 128'({in_ready, got32(), out_valid}), 128'd0);
    chk("rst_flight8", 128'({in_ready8, got8(), out_valid8}), 128'd0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      chk("no_stale", 128'({out_valid, out_valid8}), 128'd0);
    end
    chk("ready_after_flush", 128'(in_ready), 128'd1);

    // random traffic with random back-pressure
    repeat (3000)
      step($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 20 && (q32.size() + q8.size()) != 0; i++) idle(1'b1);
    chk("final_drain", 128'(q32.size() + q8.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_prefix_adder.md
Name: pipelined_prefix_adder

Overview:
- Parametrised, 3-stage pipelined parallel-prefix adder/subtractor. It is the successor to the fixed-size group carry-lookahead tree.
- Generalises operand width, group size and group count. Adds subtract modes, carry-in, flags, a tag sideband and valid/ready flow control.
- Sits in the EXU as the shared add/sub/compare unit feeding ALU writeback and branch compare.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of GROUP.
- GROUP, 4, bits per lookahead group. NGRP = WIDTH/GROUP must be a power of 2, ≥2.
- TAGW, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input operation valid
- in_ready  out  1  block can accept an operation this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in (used by ADD and SBB only)
- in_op  in  2  00 ADD, 01 SUB, 10 SBB, 11 ADC-reserved (treated as ADD)
- in_tag  in  TAGW  sideband, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of MSB
- out_ovf  out  1  signed overflow
- out_zero  out  1  out_sum == 0
- out_lt_s  out  1  signed A<B (SUB/SBB only, else 0)
- out_lt_u  out  1  unsigned A<B (SUB/SBB only, else 0)
- out_tag  out  TAGW  tag of the result

Behaviour:
- Clock and reset: one clock domain (clk). rst is synchronous and active-high. While rst is high at a rising edge, all stage valids and all output registers go to 0. Every output, including in_ready, is therefore 0/0x0 in the cycle after reset is sampled.
- Operand preparation:
  - ADD/11: B' = B, c0 = in_cin.
  - SUB: B' = ~B, c0 = 1 (in_cin ignored).
  - SBB: B' = ~B, c0 = in_cin (in_cin = 1 means no borrow).
- S1 (register 1):
  - Per-bit g = A&B', p = A^B'.
  - Per-group (G,P) via ripple lookahead inside the group.
  - Register A[MSB], B'[MSB], p vector, per-group G/P, c0, op and tag.
- S2 (register 2):
  - Sklansky prefix over NGRP groups, log2(NGRP) levels.
  - Group carry-in C[k] = G[0..k-1] combined with c0, where C[0] = c0.
  - Register C vector, p vector, group-internal g, plus the sideband.
- S3 (register 3 = output):
  - Sum bit i = p[i] ^ c_i, with c_i from the group carry-in and in-group rippling.
  - cout = carry out of the MSB.
  - ovf = c_in(MSB) ^ cout.
  - zero = ~|sum.
  - lt_s = sum[MSB] ^ ovf; lt_u = ~cout. Both are forced to 0 for ADD/11.
- Arithmetic:
  - All arithmetic is modulo 2^WIDTH. No saturation.
  - Results must equal {cout,sum} = A + B' + c0 bit-exactly.
- Flow control:
  - Each stage k has valid v_k. Stage k loads when ~v_k | adv_{k+1}, where adv_4 = out_ready.
  - in_ready = ~v1 | adv2 (purely combinational from state and out_ready). An accept requires in_valid & in_ready.
  - Throughput is 1 op/cycle when out_ready stays high.
  - Latency is exactly 3 cycles from accept to out_valid.
  - Results leave in order. No drop, no duplication.
- Stalls:
  - While out_valid & ~out_ready, all out_* are held stable.
  - Bubbles collapse, so a full stall buffers exactly 3 ops and then in_ready = 0.
- Simultaneous events:
  - Accept and emit in the same cycle are allowed.
  - rst overrides everything. Ops in flight are discarded and nothing is emitted.
- Boundaries:
  - WIDTH = 2*GROUP means a 1-level tree.
  - Illegal parameters (WIDTH%GROUP ≠ 0, or NGRP not a power of 2) are rejected by an elaboration-time $error.

Decomposition:
- Shared package (extend define.v):
  - op encodings (ADD/SUB/SBB).
  - Default WIDTH/GROUP, replacing the INPUTSIZE/GROUPSIZE macros for new code.
  - Flag bit order of the result struct.
- One natural sub-module: prefix_gp_tree.
  - Parametrised combinational Sklansky tree on NGRP (G,P) pairs with carry-in.
  - Instantiates the existing o_logic cell per node.
  - Reusable by the future multiplier final adder.

Test Plan:
- WIDTH=32,GROUP=4: ADD 0xFFFFFFFF+0x1, cin=0 -> sum 0x0, cout 1, zero 1, ovf 0, lt_s/lt_u 0, out_valid 3 cycles after accept.
- SUB 0x7FFFFFFF−0xFFFFFFFF -> sum 0x80000000, ovf 1, cout 0, lt_s 0, lt_u 1. SBB 5−3 with cin=0 -> sum 0x1, cout 1.
- Stream tags 0..7 back-to-back with out_ready=1 -> in_ready stays 1, outputs on 8 consecutive cycles, tags 0..7 in order.
- Hold out_ready=0 for 6 cycles while in_valid=1 -> exactly 3 accepted, in_ready falls, out_* stable. On release, 3 results then resume, no loss or duplication.
- Assert rst for 1 cycle with 3 ops in flight -> next cycle out_valid=0 and all outputs 0, in_ready=1 after, no stale result ever emitted.
- Param sweep (64/8, 16/2, 8/4): 10k random ops per op code vs a behavioural A+B'+c0 model -> zero mismatches.
